// File: rtl/clmul_iter_unit_if.sv
// clmul_iter_unit_if
//   Issue and writeback bundle for the iterative carry-less multiplier.
//   The names match the unit's port list, so the _i/_o suffixes are seen from the unit.
//
//   Issue side     : flush_i, valid_i, ready_o, op_i, operand_a_i, operand_b_i, trans_id_i
//   Writeback side : valid_o, result_ready_i, result_o, trans_id_o
//
//   Modports
//     master : the issuing pipeline / writeback consumer
//     slave  : the multiplier unit
interface clmul_iter_unit_if #(
  parameter int XLEN          = 64,
  parameter int TRANS_ID_BITS = 3
);
  logic                     flush_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [1:0]               op_i;
  logic [XLEN-1:0]          operand_a_i;
  logic [XLEN-1:0]          operand_b_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic                     valid_o;
  logic                     result_ready_i;
  logic [XLEN-1:0]          result_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;

  modport master (
    output flush_i, valid_i, op_i, operand_a_i, operand_b_i, trans_id_i, result_ready_i,
    input  ready_o, valid_o, result_o, trans_id_o
  );

  modport slave (
    input  flush_i, valid_i, op_i, operand_a_i, operand_b_i, trans_id_i, result_ready_i,
    output ready_o, valid_o, result_o, trans_id_o
  );
endinterface

// File: rtl/clmul_iter_unit.sv
// clmul_iter_unit
//   Iterative carry-less multiplier for CLMUL / CLMULH / CLMULR.
//   Consumes BITS_PER_CYCLE multiplier bits per BUSY cycle. With EARLY_EXIT,
//   BUSY ends as soon as the remaining multiplier bits are all zero.
//
//   Ports
//     clk_i  : clock
//     rst_i  : asynchronous, active-high reset
//     bus    : clmul_iter_unit_if.slave (issue handshake, flush, writeback handshake)
//
//   States
//     S_IDLE | ready for an issue
//     S_BUSY | accumulating partial products
//     S_DONE | result held, waiting for writeback
//
//   All outputs are registered; ready_o and valid_o mirror the state.
module clmul_iter_unit #(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 4,
  parameter int EARLY_EXIT     = 1,
  parameter int TRANS_ID_BITS  = 3
) (
  input logic              clk_i,
  input logic              rst_i,
  clmul_iter_unit_if.slave bus
);

  localparam int STEPS = XLEN / BITS_PER_CYCLE;
  // A one-step configuration still needs a one-bit counter.
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEPS - 1);

  localparam logic [1:0] OP_CLMULH = 2'd1;
  localparam logic [1:0] OP_CLMULR = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state;
  logic [2*XLEN-1:0]        acc;
  logic [2*XLEN-1:0]        a_sh;
  logic [XLEN-1:0]          b_rem;
  logic [CNT_W-1:0]         cnt;
  logic [1:0]               op;
  logic [TRANS_ID_BITS-1:0] tag;

  logic [2*XLEN-1:0]        acc_step;
  logic [XLEN-1:0]          b_next;
  logic                     last_step;
  logic [XLEN-1:0]          result_sel;

  // One BUSY step: fold in the partial products of the low BITS_PER_CYCLE
  // multiplier bits, then decide whether this was the final step.
  always_comb begin
    acc_step = acc;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (b_rem[j]) begin
        acc_step = acc_step ^ (a_sh << j);
      end
    end
    b_next    = b_rem >> BITS_PER_CYCLE;
    last_step = (cnt == CNT_LAST) || ((EARLY_EXIT != 0) && (b_next == '0));
  end

  // Result selection works on the post-step accumulator so the result can be
  // registered on the same edge that enters S_DONE. Reserved op 3 acts as CLMUL.
  always_comb begin
    result_sel = acc_step[XLEN-1:0];
    case (op)
      OP_CLMULH: result_sel = acc_step[2*XLEN-1:XLEN];
      OP_CLMULR: result_sel = acc_step[2*XLEN-2:XLEN-1];
      default:   result_sel = acc_step[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state          <= S_IDLE;
      acc            <= '0;
      a_sh           <= '0;
      b_rem          <= '0;
      cnt            <= '0;
      op             <= '0;
      tag            <= '0;
      bus.ready_o    <= 1'b1;
      bus.valid_o    <= 1'b0;
      bus.result_o   <= '0;
      bus.trans_id_o <= '0;
    end else if (bus.flush_i) begin
      // Flush wins over issue, BUSY completion and writeback.
      state       <= S_IDLE;
      bus.ready_o <= 1'b1;
      bus.valid_o <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.valid_i) begin
            acc         <= '0;
            a_sh        <= {{XLEN{1'b0}}, bus.operand_a_i};
            b_rem       <= bus.operand_b_i;
            cnt         <= '0;
            op          <= bus.op_i;
            tag         <= bus.trans_id_i;
            state       <= S_BUSY;
            bus.ready_o <= 1'b0;
          end
        end

        S_BUSY: begin
          acc   <= acc_step;
          a_sh  <= a_sh << BITS_PER_CYCLE;
          b_rem <= b_next;
          cnt   <= cnt + 1'b1;
          if (last_step) begin
            state          <= S_DONE;
            bus.valid_o    <= 1'b1;
            bus.result_o   <= result_sel;
            bus.trans_id_o <= tag;
          end
        end

        S_DONE: begin
          if (bus.result_ready_i) begin
            state       <= S_IDLE;
            bus.valid_o <= 1'b0;
            bus.ready_o <= 1'b1;
          end
        end

        default: begin
          state       <= S_IDLE;
          bus.valid_o <= 1'b0;
          bus.ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clmul_iter_unit.sv
// tb_clmul_iter_unit
//   Directed and randomised checks of clmul_iter_unit across four configurations:
//     0: XLEN=64 BPC=4 EARLY_EXIT=0
//     1: XLEN=64 BPC=4 EARLY_EXIT=1
//     2: XLEN=32 BPC=1 EARLY_EXIT=0
//     3: XLEN=64 BPC=8 EARLY_EXIT=1
//   'sel' routes the shared stimulus to one unit and muxes its outputs back.
module tb_clmul_iter_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  sel;
  logic        flush, valid, rr;
  logic [1:0]  op;
  logic [63:0] a, b;
  logic [2:0]  tid;

  logic        o_ready, o_valid;
  logic [63:0] o_result;
  logic [2:0]  o_tid;

  int checks   = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  clmul_iter_unit_if #(.XLEN(64), .TRANS_ID_BITS(3)) if0 ();
  clmul_iter_unit_if #(.XLEN(64), .TRANS_ID_BITS(3)) if1 ();
  clmul_iter_unit_if #(.XLEN(32), .TRANS_ID_BITS(3)) if2 ();
  clmul_iter_unit_if #(.XLEN(64), .TRANS_ID_BITS(3)) if3 ();

  assign if0.flush_i = flush && (sel == 2'd0);
  assign if0.valid_i = valid && (sel == 2'd0);
  assign if0.op_i = op;
  assign if0.operand_a_i = a;
  assign if0.operand_b_i = b;
  assign if0.trans_id_i = tid;
  assign if0.result_ready_i = rr;

  assign if1.flush_i = flush && (sel == 2'd1);
  assign if1.valid_i = valid && (sel == 2'd1);
  assign if1.op_i = op;
  assign if1.operand_a_i = a;
  assign if1.operand_b_i = b;
  assign if1.trans_id_i = tid;
  assign if1.result_ready_i = rr;

  assign if2.flush_i = flush && (sel == 2'd2);
  assign if2.valid_i = valid && (sel == 2'd2);
  assign if2.op_i = op;
  assign if2.operand_a_i = a[31:0];
  assign if2.operand_b_i = b[31:0];
  assign if2.trans_id_i = tid;
  assign if2.result_ready_i = rr;

  assign if3.flush_i = flush && (sel == 2'd3);
  assign if3.valid_i = valid && (sel == 2'd3);
  assign if3.op_i = op;
  assign if3.operand_a_i = a;
  assign if3.operand_b_i = b;
  assign if3.trans_id_i = tid;
  assign if3.result_ready_i = rr;

  clmul_iter_unit #(.XLEN(64), .BITS_PER_CYCLE(4), .EARLY_EXIT(0), .TRANS_ID_BITS(3))
    dut0 (.clk_i(clk_i), .rst_i(rst_i), .bus(if0));
  clmul_iter_unit #(.XLEN(64), .BITS_PER_CYCLE(4), .EARLY_EXIT(1), .TRANS_ID_BITS(3))
    dut1 (.clk_i(clk_i), .rst_i(rst_i), .bus(if1));
  clmul_iter_unit #(.XLEN(32), .BITS_PER_CYCLE(1), .EARLY_EXIT(0), .TRANS_ID_BITS(3))
    dut2 (.clk_i(clk_i), .rst_i(rst_i), .bus(if2));
  clmul_iter_unit #(.XLEN(64), .BITS_PER_CYCLE(8), .EARLY_EXIT(1), .TRANS_ID_BITS(3))
    dut3 (.clk_i(clk_i), .rst_i(rst_i), .bus(if3));

  always_comb begin
    o_ready  = if0.ready_o;
    o_valid  = if0.valid_o;
    o_result = if0.result_o;
    o_tid    = if0.trans_id_o;
    case (sel)
      2'd1: begin
        o_ready = if1.ready_o; o_valid = if1.valid_o;
        o_result = if1.result_o; o_tid = if1.trans_id_o;
      end
      2'd2: begin
        o_ready = if2.ready_o; o_valid = if2.valid_o;
        o_result = {32'b0, if2.result_o}; o_tid = if2.trans_id_o;
      end
      2'd3: begin
        o_ready = if3.ready_o; o_valid = if3.valid_o;
        o_result = if3.result_o; o_tid = if3.trans_id_o;
      end
      default: ;
    endcase
  end

  // Bit-serial reference: full 2*xlen product, then select the window.
  function automatic logic [63:0] clmul_ref(input logic [63:0] av, input logic [63:0] bv,
                                             input int xlen, input logic [1:0] o);
    logic [127:0] p;
    logic [127:0] aw;
    logic [63:0]  mask;
    mask = (xlen == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << xlen) - 64'h1);
    aw = {64'b0, av & mask};
    p = '0;
    for (int i = 0; i < xlen; i++) begin
      if (bv[i]) p = p ^ (aw << i);
    end
    case (o)
      2'd1:    clmul_ref = 64'(p >> xlen) & mask;
      2'd2:    clmul_ref = 64'(p >> (xlen - 1)) & mask;
      default: clmul_ref = p[63:0] & mask;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op with result_ready_i high; lat counts cycles from the accept
  // edge to the first cycle with valid_o (999 when it never arrives).
  task automatic run_op(input logic [1:0] o, input logic [63:0] av, input logic [63:0] bv,
                        input logic [2:0] t, output logic [63:0] res,
                        output logic [2:0] tido, output int lat);
    int w;
    w = 0;
    op = o; a = av; b = bv; tid = t; valid = 1'b1;
    while (!o_ready && w < 100) begin tick(); w++; end
    tick();
    valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 200) begin tick(); lat++; end
    if (!o_valid) lat = 999;
    res  = o_result;
    tido = o_tid;
    if (o_valid) tick();
  endtask

  task automatic test_reset();
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      #1;
      checks++;
      if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready sel=%0d got=%b exp=1", s, o_ready); end
      checks++;
      if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid sel=%0d got=%b exp=0", s, o_valid); end
      checks++;
      if (o_result !== 64'h0) begin failures++; $display("FAIL reset_result sel=%0d got=%h exp=0", s, o_result); end
      checks++;
      if (o_tid !== 3'd0) begin failures++; $display("FAIL reset_tid sel=%0d got=%0d exp=0", s, o_tid); end
    end
  endtask

  task automatic test_basic();
    logic [63:0] r; logic [2:0] t; int lat;
    sel = 2'd0;
    run_op(2'd0, 64'h3, 64'h3, 3'd5, r, t, lat);
    checks++;
    if (r !== 64'h5) begin failures++; $display("FAIL basic_clmul got=%h exp=5", r); end
    checks++;
    if (t !== 3'd5) begin failures++; $display("FAIL basic_tid got=%0d exp=5", t); end
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL basic_latency got=%0d exp=17", lat); end
    run_op(2'd1, 64'h3, 64'h3, 3'd1, r, t, lat);
    checks++;
    if (r !== 64'h0) begin failures++; $display("FAIL basic_clmulh got=%h exp=0", r); end
    run_op(2'd2, 64'h3, 64'h3, 3'd2, r, t, lat);
    checks++;
    if (r !== 64'h0) begin failures++; $display("FAIL basic_clmulr got=%h exp=0", r); end
    run_op(2'd3, 64'h3, 64'h3, 3'd3, r, t, lat);
    checks++;
    if (r !== 64'h5) begin failures++; $display("FAIL basic_reserved got=%h exp=5", r); end
  endtask

  task automatic test_top_bits();
    logic [63:0] r; logic [2:0] t; int lat;
    sel = 2'd0;
    run_op(2'd0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'd4, r, t, lat);
    checks++;
    if (r !== 64'h0) begin failures++; $display("FAIL top_clmul got=%h exp=0", r); end
    run_op(2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'd4, r, t, lat);
    checks++;
    if (r !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL top_clmulh got=%h exp=4000000000000000", r); end
    run_op(2'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'd4, r, t, lat);
    checks++;
    if (r !== 64'h8000_0000_0000_0000) begin failures++; $display("FAIL top_clmulr got=%h exp=8000000000000000", r); end
  endtask

  task automatic test_early_exit();
    logic [63:0] r; logic [2:0] t; int lat;
    sel = 2'd1;
    run_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 3'd1, r, t, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL ee_b1_latency got=%0d exp=2", lat); end
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL ee_b1_result got=%h exp=ffffffffffffffff", r); end
    run_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100, 3'd2, r, t, lat);
    checks++;
    if (lat !== 4) begin failures++; $display("FAIL ee_b100_latency got=%0d exp=4", lat); end
    checks++;
    if (r !== 64'hFFFF_FFFF_FFFF_FF00) begin failures++; $display("FAIL ee_b100_result got=%h exp=ffffffffffffff00", r); end
    run_op(2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd3, r, t, lat);
    checks++;
    if (lat !== 2) begin failures++; $display("FAIL ee_b0_latency got=%0d exp=2", lat); end
    checks++;
    if (r !== 64'h0) begin failures++; $display("FAIL ee_b0_result got=%h exp=0", r); end
    run_op(2'd0, 64'h1, 64'h8000_0000_0000_0000, 3'd4, r, t, lat);
    checks++;
    if (lat !== 17) begin failures++; $display("FAIL ee_btop_latency got=%0d exp=17", lat); end
  endtask

  task automatic test_backpressure();
    logic [63:0] r0; logic [2:0] t0; int w;
    sel = 2'd0; rr = 1'b0;
    op = 2'd0; a = 64'h3; b = 64'h5; tid = 3'd6; valid = 1'b1;
    tick();
    valid = 1'b0;
    w = 0;
    while (!o_valid && w < 100) begin tick(); w++; end
    checks++;
    if (o_valid !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout got=%b exp=1", o_valid); end
    r0 = o_result; t0 = o_tid;
    checks++;
    if (r0 !== 64'hF || t0 !== 3'd6) begin failures++; $display("FAIL bp_result got=%h/%0d exp=f/6", r0, t0); end
    valid = 1'b1; tid = 3'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (o_valid !== 1'b1 || o_result !== r0 || o_tid !== t0 || o_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got v=%b r=%h t=%0d rdy=%b exp v=1 r=f t=6 rdy=0",
                 i, o_valid, o_result, o_tid, o_ready);
      end
    end
    valid = 1'b0; rr = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL bp_release got rdy=%b v=%b exp rdy=1 v=0", o_ready, o_valid); end
    tick();
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL bp_no_accept got rdy=%b exp=1", o_ready); end
  endtask

  task automatic test_flush();
    logic [63:0] r; logic [2:0] t; int lat; int seen;
    sel = 2'd0;
    op = 2'd0; a = 64'h3; b = 64'h3; tid = 3'd6; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin failures++; $display("FAIL flush_busy got rdy=%b v=%b exp rdy=1 v=0", o_ready, o_valid); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (o_valid) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_no_result got=%0d valid cycles exp=0", seen); end
    tid = 3'd7; valid = 1'b1; flush = 1'b1;
    tick();
    valid = 1'b0; flush = 1'b0;
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL flush_issue_dropped got rdy=%b exp=1", o_ready); end
    seen = 0;
    for (int i = 0; i < 20; i++) begin tick(); if (o_valid) seen++; end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL flush_issue_no_result got=%0d exp=0", seen); end
    run_op(2'd0, 64'h3, 64'h5, 3'd2, r, t, lat);
    checks++;
    if (r !== 64'hF || t !== 3'd2) begin failures++; $display("FAIL flush_next got=%h/%0d exp=f/2", r, t); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    sel = 2'd1; rr = 1'b1;
    op = 2'd0; a = 64'h7; b = 64'h1; tid = 3'd3; valid = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 12; c++) begin
      if (o_ready) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      tick();
    end
    valid = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (second - first !== 3) begin failures++; $display("FAIL b2b_interval got=%0d exp=3", second - first); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] r; logic [2:0] t; int lat;
    sel = 2'd1;
    run_op(2'd0, 64'h3, 64'h3, 3'd5, r, t, lat);
    checks++;
    if (r !== 64'h5) begin failures++; $display("FAIL rstmid_pre got=%h exp=5", r); end
    op = 2'd0; a = 64'hFFFF; b = 64'h8000_0000_0000_0000; tid = 3'd4; valid = 1'b1;
    tick();
    valid = 1'b0;
    tick(); tick();
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_result !== 64'h0 || o_tid !== 3'd0) begin
      failures++;
      $display("FAIL rstmid_async got v=%b rdy=%b r=%h t=%0d exp v=0 rdy=1 r=0 t=0", o_valid, o_ready, o_result, o_tid);
    end
    valid = 1'b1;
    tick();
    checks++;
    if (o_ready !== 1'b1) begin failures++; $display("FAIL rstmid_valid_ignored got rdy=%b exp=1", o_ready); end
    valid = 1'b0;
    #2 rst_i = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [63:0] r, ra, rb, exp; logic [2:0] t; logic [1:0] ro; int lat; int xl;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      xl = (s == 2) ? 32 : 64;
      for (int n = 0; n < 250; n++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom} >> $urandom_range(0, 63);
        ro = 2'($urandom_range(0, 3));
        if (xl == 32) begin ra = {32'b0, ra[31:0]}; rb = {32'b0, rb[31:0]}; end
        exp = clmul_ref(ra, rb, xl, ro);
        run_op(ro, ra, rb, 3'(n), r, t, lat);
        checks++;
        if (r !== exp || t !== 3'(n)) begin
          failures++;
          $display("FAIL random sel=%0d op=%0d a=%h b=%h got=%h/%0d exp=%h/%0d", s, ro, ra, rb, r, t, exp, 3'(n));
        end
      end
    end
  endtask

  initial begin
    rst_i = 1'b1; sel = 2'd0; flush = 1'b0; valid = 1'b0; rr = 1'b1;
    op = 2'd0; a = '0; b = '0; tid = '0;
    tick();
    test_reset();
    #2 rst_i = 1'b0;
    tick();
    test_basic();
    test_top_bits();
    test_early_exit();
    test_backpressure();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
